panel_mem_seq: RTL and testbench
================================

# panel_mem_seq

Front-panel memory access sequencer. It turns the load, store-increment and decrement buttons into single-byte bus transactions on the memory port while the CPU is halted. It sits between the front-panel display/keypad logic (which supplies the 24-bit entry `disp`) and the memory arbiter. It also owns the panel address register shown on the address LEDs and latches the byte read back for display.

## Interface
Parameters:
- `ADDR_W`, 16: panel address / memory address width.
- `DATA_W`, 8: memory data width.
- `TIMEOUT_CYC`, 255: grant-wait limit in cycles; used only with the timeout feature.

Ports:
- `clk` in 1: system clock; the block has one clock.
- `rst` in 1: reset, synchronous and active-high.
- `stopped` in 1: CPU halted; panel accesses are allowed only while high.
- `b_load` in 1: load button level (already debounced).
- `b_storeinc` in 1: store-and-increment button level.
- `b_dec` in 1: decrement button level.
- `disp` in 24: current panel entry value.
- `addr` out ADDR_W: panel address register.
- `data_out` out DATA_W: last byte read at `addr`.
- `busy` out 1: high whenever state ≠ IDLE.
- `clear_disp` out 1: one-cycle pulse that tells the panel to clear its entry.
- `err` out 1: sticky timeout flag.
- `mem_req` out 1: bus request.
- `mem_we` out 1: write enable, qualified by `mem_req`.
- `mem_addr` out ADDR_W: bus address, always equal to `addr`.
- `mem_wdata` out DATA_W: write data.
- `mem_gnt` in 1: grant; the transfer completes in the cycle where `mem_req & mem_gnt`.
- `mem_rdata` in DATA_W: read data, valid in the grant cycle.

## Operation
- Rising-edge detection on `b_load`, `b_storeinc`, `b_dec` and `stopped`, using a registered previous value. An edge is a one-cycle pulse that is active in the same cycle the level first goes high.
- Commands are accepted only in IDLE with `stopped` high. Edges arriving at any other time are dropped, not queued.
- Simultaneous edges use fixed priority: load > storeinc > dec.
- A rising edge on `stopped` in IDLE starts a READ of the current `addr`. This refreshes `data_out`.
- States:
  - IDLE: `mem_req`=0.
  - LOAD: `addr <= disp[15:0]`, then go to READ.
  - WRITE: `mem_req`=1, `mem_we`=1, `mem_wdata = disp[7:0]`. Held until grant, then go to INC.
  - INC: `addr <= addr + 1`, then go to READ.
  - DEC: `addr <= addr - 1`, then go to READ.
  - READ: `mem_req`=1, `mem_we`=0. On grant, `data_out <= mem_rdata`, then go to DONE.
  - DONE: `clear_disp`=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 gives 0x0000; 0x0000−1 gives 0xFFFF.
- While `mem_req`=1 and no grant has arrived, `mem_addr`, `mem_we` and `mem_wdata` stay stable.
- If `stopped` falls in WRITE or READ without a grant in that cycle:
  - `mem_req` drops next cycle and the state returns to IDLE.
  - No address change and no `clear_disp`.
  - A grant in the same cycle as `stopped` falling counts: the transfer completes and the sequence continues.
- `rst` mid-operation returns everything to reset values in the next cycle. The bus request is dropped with no handshake.

## Timing
- Reset values: `addr`=0x0000, `data_out`=0x00, `busy`=0, `clear_disp`=0, `err`=0, `mem_req`=0, `mem_we`=0, `mem_wdata`=0x00. `mem_addr` follows `addr`.
- Load edge at cycle N, with immediate grant:
  - N+1: LOAD.
  - N+2: READ, `mem_req` high, `addr` already updated.
  - N+3: DONE, `data_out` valid, `clear_disp` high.
  - N+4: IDLE.
- Storeinc with immediate grant: edge N, WRITE N+1, INC N+2, READ N+3, DONE N+4, IDLE N+5.
- Each cycle of grant delay adds one cycle to the corresponding state.
- `busy` is registered and is high from N+1 through the DONE cycle.

## Configuration
- `PANEL_SEQ_TIMEOUT_EN` defined:
  - An 8-bit counter counts cycles spent in WRITE or READ without a grant.
  - When the count reaches TIMEOUT_CYC, drop `mem_req`, set `err`=1, and go to IDLE. There is no `clear_disp`.
  - `err` clears only on `rst` or on the next accepted load.
- `PANEL_SEQ_TIMEOUT_EN` undefined: the block waits indefinitely, and `err` is tied to 0.

## Structure
- Shared package `panel_seq_pkg` holds:
  - the state encoding (IDLE, LOAD, WRITE, INC, DEC, READ, DONE);
  - ADDR_W/DATA_W defaults;
  - the TIMEOUT_CYC default.
- Sub-module `panel_edge` is a single rising-edge detector with synchronous active-high reset. It is instantiated four times: the three buttons plus `stopped`.

## Test plan
- Load: `stopped`=1, `disp`=0x00C0DE, pulse `b_load`, grant immediately, `mem_rdata`=0x5A → `addr`=0xC0DE, `data_out`=0x5A, `clear_disp` pulses once at N+3.
- Store-increment: `addr`=0x1234, `disp`=0x0000A5, pulse `b_storeinc`, grant delayed 3 cycles → exactly one write of 0xA5 at 0x1234 with stable bus signals, then a read at 0x1235, final `addr`=0x1235.
- Wrap: `addr`=0xFFFF then storeinc → `addr`=0x0000; `addr`=0x0000 then dec → `addr`=0xFFFF, each followed by one read.
- Gating and priority:
  - Buttons pressed with `stopped`=0 → no `mem_req`.
  - `b_load` and `b_dec` rising in the same cycle → load only.
  - Edges while `busy` → ignored.
- Abort: drop `stopped` during WRITE while `mem_gnt`=0 → `mem_req` low next cycle, IDLE, `addr` unchanged, no `clear_disp`. A `stopped` rising edge in IDLE → a single read of `addr`.
- Timeout (`PANEL_SEQ_TIMEOUT_EN`): hold `mem_gnt`=0 for 300 cycles → `mem_req` drops after 255 cycles, `err`=1. A subsequent load clears `err`.

Source files
------------

// File: rtl/panel_seq_pkg.sv
// panel_seq_pkg: shared definitions for the front-panel memory sequencer.
//   - state_t         : sequencer state encoding
//   - ADDR_W_DEF      : default panel/memory address width
//   - DATA_W_DEF      : default memory data width
//   - TIMEOUT_CYC_DEF : default grant-wait limit (PANEL_SEQ_TIMEOUT_EN builds)
package panel_seq_pkg;

    localparam int unsigned ADDR_W_DEF      = 16;
    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_INC,
        ST_DEC,
        ST_READ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/panel_mem_seq_if.sv
// panel_mem_seq_if: single-byte memory bus between the panel sequencer and
// the memory arbiter.
//   mem_req   : bus request (sequencer -> arbiter)
//   mem_we    : write enable, qualified by mem_req
//   mem_addr  : bus address
//   mem_wdata : write data
//   mem_gnt   : grant; transfer completes when mem_req & mem_gnt
//   mem_rdata : read data, valid in the grant cycle
// Modports: master (sequencer side), slave (arbiter/memory side).
interface panel_mem_seq_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata
    );
endinterface

// File: rtl/panel_edge.sv
// panel_edge: rising-edge detector for one level input.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   level : input level (already debounced / synchronous)
//   rise  : high in the first cycle that level is high
module panel_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= level;
    end

    assign rise = level & ~prev;
endmodule

// File: rtl/panel_mem_seq.sv
// panel_mem_seq: front-panel memory access sequencer. Turns load,
// store-increment and decrement button presses into single-byte memory
// transactions while the CPU is stopped, owns the panel address register
// and latches the byte read back for display.
//   clk, rst   : clock, synchronous active-high reset
//   stopped    : CPU halted; accesses only allowed while high
//   b_load, b_storeinc, b_dec : button levels
//   disp       : 24-bit panel entry
//   addr       : panel address register (also drives bus.mem_addr)
//   data_out   : last byte read at addr
//   busy       : high whenever the sequencer is not idle
//   clear_disp : one-cycle pulse asking the panel to clear its entry
//   err        : sticky grant-timeout flag
//   bus        : memory bus (master modport)
// Optional feature macro: PANEL_SEQ_TIMEOUT_EN enables the grant-wait
// timeout and err; otherwise the sequencer waits indefinitely, err = 0.
module panel_mem_seq
    import panel_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stopped,
    input  logic              b_load,
    input  logic              b_storeinc,
    input  logic              b_dec,
    input  logic [23:0]       disp,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              clear_disp,
    output logic              err,
    panel_mem_seq_if.master   bus
);
    state_t            state;
    logic              load_e, st_e, dec_e, stop_e;
    logic              req_q, we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              waiting;   // in a bus state with no grant this cycle
    logic              tmo;       // grant wait limit reached this cycle
    logic              accept;    // commands only taken when idle and stopped

    panel_edge u_edge_load (.clk(clk), .rst(rst), .level(b_load),     .rise(load_e));
    panel_edge u_edge_st   (.clk(clk), .rst(rst), .level(b_storeinc), .rise(st_e));
    panel_edge u_edge_dec  (.clk(clk), .rst(rst), .level(b_dec),      .rise(dec_e));
    panel_edge u_edge_stop (.clk(clk), .rst(rst), .level(stopped),    .rise(stop_e));

    assign accept  = (state == ST_IDLE) && stopped;
    assign waiting = ((state == ST_WRITE) || (state == ST_READ)) && !bus.mem_gnt;

`ifdef PANEL_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    assign tmo = waiting && (wait_cnt == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + 8'd1 : '0;
            if (tmo)                   err_q <= 1'b1;
            else if (accept && load_e) err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            data_out   <= '0;
            busy       <= 1'b0;
            clear_disp <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            clear_disp <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // Fixed priority: load > storeinc > dec > stopped edge.
                        if (load_e) begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                        end else if (st_e) begin
                            state   <= ST_WRITE;
                            busy    <= 1'b1;
                            req_q   <= 1'b1;
                            we_q    <= 1'b1;
                            // Captured once so the bus stays stable while
                            // the panel entry changes during a grant wait.
                            wdata_q <= disp[DATA_W-1:0];
                        end else if (dec_e) begin
                            state <= ST_DEC;
                            busy  <= 1'b1;
                        end else if (stop_e) begin
                            state <= ST_READ;
                            busy  <= 1'b1;
                            req_q <= 1'b1;
                            we_q  <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    addr  <= disp[ADDR_W-1:0];
                    state <= ST_READ;
                    req_q <= 1'b1;
                    we_q  <= 1'b0;
                end
                ST_INC, ST_DEC: begin
                    addr  <= (state == ST_INC) ? addr + 1'b1 : addr - 1'b1;
                    state <= ST_READ;
                    req_q <= 1'b1;
                    we_q  <= 1'b0;
                end
                ST_WRITE, ST_READ: begin
                    // A grant wins over stopped falling in the same cycle.
                    if (bus.mem_gnt) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (state == ST_READ) begin
                            data_out   <= bus.mem_rdata;
                            clear_disp <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_INC;
                        end
                    end else if (!stopped || tmo) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_panel_mem_seq.sv
// tb_panel_mem_seq: scoreboard bench for panel_mem_seq. Directed button
// sequences push expected bus transactions into a queue; an independent
// monitor pops and compares on every handshake. A responder process models
// the arbiter with a programmable grant delay.
module tb_panel_mem_seq;
    import panel_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stopped, b_load, b_storeinc, b_dec;
    logic [23:0] disp;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        busy, clear_disp, err;

    panel_mem_seq_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    panel_mem_seq #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst(rst), .stopped(stopped), .b_load(b_load),
        .b_storeinc(b_storeinc), .b_dec(b_dec), .disp(disp), .addr(addr),
        .data_out(data_out), .busy(busy), .clear_disp(clear_disp), .err(err),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
    } txn_t;

    txn_t        expq[$];
    int unsigned n_chk = 0, n_pass = 0;
    bit          gnt_en = 1'b1;
    int          gnt_delay = 0;
    logic [7:0]  rd_val = 8'h00;
    int          req_cycles = 0, clr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic we, input logic [15:0] a, input logic [7:0] d);
        txn_t t;
        t.we = we; t.a = a; t.d = d;
        expq.push_back(t);
    endtask

    task automatic press(input bit l, input bit s, input bit d);
        @(negedge clk);
        b_load = l; b_storeinc = s; b_dec = d;
        @(negedge clk);
        b_load = 1'b0; b_storeinc = 1'b0; b_dec = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        check("wait_idle", busy, 0);
    endtask

    // Arbiter model: grants after gnt_delay request cycles, one cycle wide.
    initial begin
        int w;
        w = 0;
        bus.mem_gnt = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rdata = rd_val;
            if (bus.mem_gnt) begin
                bus.mem_gnt = 1'b0;
                w = 0;
            end else if (bus.mem_req && gnt_en) begin
                if (w >= gnt_delay) bus.mem_gnt = 1'b1;
                else w++;
            end else begin
                w = 0;
            end
        end
    end

    // Monitor: compare each handshake with the head of the scoreboard and
    // verify the bus held still while waiting for the grant.
    initial begin
        txn_t s, cur, e;
        bit   pw;
        int   bad;
        pw = 1'b0; bad = 0; s = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                pw = 1'b0; bad = 0;
            end else begin
                if (bus.mem_req) req_cycles++;
                if (clear_disp)  clr_cnt++;
                cur = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
                if (bus.mem_req && pw && cur !== s) bad++;
                if (bus.mem_req && bus.mem_gnt) begin
                    if (expq.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_txn: got we=%0b addr=%0h wdata=%0h, required none",
                                 cur.we, cur.a, cur.d);
                    end else begin
                        e = expq.pop_front();
                        check("txn_we", cur.we, e.we);
                        check("txn_addr", cur.a, e.a);
                        if (e.we) check("txn_wdata", cur.d, e.d);
                        check("txn_stable", bad, 0);
                    end
                    pw = 1'b0; bad = 0;
                end else if (bus.mem_req) begin
                    if (!pw) s = cur;
                    pw = 1'b1;
                end else begin
                    pw = 1'b0; bad = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, c0;
        rst = 1'b1; stopped = 1'b0; b_load = 1'b0; b_storeinc = 1'b0; b_dec = 1'b0;
        disp = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rst_addr", addr, 16'h0000);
        check("rst_data_out", data_out, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_clear_disp", clear_disp, 0);
        check("rst_err", err, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_wdata", bus.mem_wdata, 8'h00);

        // stopped rising in IDLE: one read of the current address
        rd_val = 8'h3C;
        push(1'b0, 16'h0000, 8'h00);
        @(negedge clk); stopped = 1'b1;
        wait_idle(20);
        check("stop_read_data", data_out, 8'h3C);

        // Load with immediate grant, cycle exact
        disp = 24'h00C0DE; rd_val = 8'h5A; c0 = clr_cnt;
        push(1'b0, 16'hC0DE, 8'h00);
        @(negedge clk); b_load = 1'b1;
        @(posedge clk); #1;
        check("load_n1_busy", busy, 1);
        check("load_n1_req", bus.mem_req, 0);
        @(negedge clk); b_load = 1'b0;
        @(posedge clk); #1;
        check("load_n2_req", bus.mem_req, 1);
        check("load_n2_addr", addr, 16'hC0DE);
        check("load_n2_mem_addr", bus.mem_addr, 16'hC0DE);
        check("load_n2_we", bus.mem_we, 0);
        @(posedge clk); #1;
        check("load_n3_clear", clear_disp, 1);
        check("load_n3_data", data_out, 8'h5A);
        check("load_n3_busy", busy, 1);
        @(posedge clk); #1;
        check("load_n4_clear", clear_disp, 0);
        check("load_n4_busy", busy, 0);
        check("load_clear_count", clr_cnt - c0, 1);

        // Store-increment with 3-cycle grant delay; entry changes mid-wait
        disp = 24'h001234; rd_val = 8'h11;
        push(1'b0, 16'h1234, 8'h00);
        press(1, 0, 0); wait_idle(20);
        gnt_delay = 3; disp = 24'h0000A5; rd_val = 8'h77;
        push(1'b1, 16'h1234, 8'hA5);
        push(1'b0, 16'h1235, 8'hA5);
        press(0, 1, 0);
        disp = 24'h000077;
        wait_idle(40);
        gnt_delay = 0;
        check("storeinc_addr", addr, 16'h1235);
        check("storeinc_data", data_out, 8'h77);
        check("storeinc_queue", expq.size(), 0);

        // Wrap-around in both directions
        disp = 24'h00FFFF;
        push(1'b0, 16'hFFFF, 8'h00);
        press(1, 0, 0); wait_idle(20);
        disp = 24'h0000C3;
        push(1'b1, 16'hFFFF, 8'hC3);
        push(1'b0, 16'h0000, 8'hC3);
        press(0, 1, 0); wait_idle(20);
        check("wrap_inc_addr", addr, 16'h0000);
        push(1'b0, 16'hFFFF, 8'hC3);
        press(0, 0, 1); wait_idle(20);
        check("wrap_dec_addr", addr, 16'hFFFF);

        // Buttons ignored while running
        @(negedge clk); stopped = 1'b0;
        r0 = req_cycles;
        press(1, 0, 0); press(0, 1, 0); press(0, 0, 1);
        repeat (3) @(negedge clk);
        #3;
        check("gate_no_req", req_cycles - r0, 0);
        check("gate_busy", busy, 0);
        check("gate_addr", addr, 16'hFFFF);
        push(1'b0, 16'hFFFF, 8'hC3);
        @(negedge clk); stopped = 1'b1;
        wait_idle(20);

        // Simultaneous load and dec: load wins
        disp = 24'h00BEEF;
        push(1'b0, 16'hBEEF, 8'hC3);
        press(1, 0, 1); wait_idle(20);
        check("prio_addr", addr, 16'hBEEF);
        check("prio_queue", expq.size(), 0);

        // Edges while busy are dropped
        gnt_delay = 5; disp = 24'h000100;
        push(1'b0, 16'h0100, 8'hC3);
        press(1, 0, 0);
        press(0, 1, 1);
        wait_idle(40);
        gnt_delay = 0;
        repeat (4) @(negedge clk);
        check("busy_ignore_addr", addr, 16'h0100);
        check("busy_ignore_queue", expq.size(), 0);
        check("busy_ignore_idle", busy, 0);

        // Abort: stopped falls during WRITE with no grant
        gnt_en = 1'b0; disp = 24'h000011;
        press(0, 1, 0);
        repeat (2) @(negedge clk);
        c0 = clr_cnt;
        stopped = 1'b0;
        @(posedge clk); #1;
        check("abort_req", bus.mem_req, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", addr, 16'h0100);
        repeat (3) @(negedge clk);
        #3;
        check("abort_no_clear", clr_cnt - c0, 0);
        gnt_en = 1'b1; rd_val = 8'h6B;
        push(1'b0, 16'h0100, 8'hA5);
        @(negedge clk); stopped = 1'b1;
        wait_idle(20);
        check("abort_reread_data", data_out, 8'h6B);

`ifdef PANEL_SEQ_TIMEOUT_EN
        gnt_en = 1'b0; disp = 24'h000022;
        press(0, 1, 0);
        r0 = req_cycles;
        repeat (300) @(negedge clk);
        #3;
        check("tmo_req_cycles", req_cycles - r0, 255);
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_addr", addr, 16'h0100);
        gnt_en = 1'b1; disp = 24'h000200;
        push(1'b0, 16'h0200, 8'h22);
        press(1, 0, 0); wait_idle(20);
        check("tmo_err_cleared", err, 0);
`else
        check("no_tmo_err", err, 0);
`endif

        repeat (3) @(negedge clk);
        check("final_queue_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
